ram_bist_ctrl: RTL

Built-in self-test initiator for the single-port 32-bit LUT RAM. The block drives the RAM's write-enable, address and write-data ports and consumes its registered read data. It runs a full-array write/read-back sweep on request, then reports pass/fail, a saturating miscompare count and the first failing address. It sits between the RAM and the test/status logic and owns the RAM port while busy.

---
 rtl/ram_bist_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ram_bist_ctrl.sv
// Write/read-back BIST for a 1-cycle-latency single-port RAM; done 2D+2 cycles after start.
// With BIST_INV_PASS_EN defined, a second sweep uses the inverted pattern (done at 4D+3).
module ram_bist_ctrl #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] pat_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] din_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [15:0]   err_q;
  logic [AW-1:0] ferr_q;
  logic          cmp_vld_q;
  logic [AW-1:0] cmp_addr_q;
  logic [DW-1:0] cmp_exp_q;

  logic [AW-1:0] addr_inc;
  logic          addr_last;
  logic [DW-1:0] pat_eff;
  logic          mismatch;
  logic [15:0]   err_d;
  logic [AW-1:0] ferr_d;

  assign addr_inc  = addr_q + 1'b1;
  assign addr_last = &addr_q;

`ifdef BIST_INV_PASS_EN
  logic inv_q;
  assign pat_eff = inv_q ? ~pat_q : pat_q;
`else
  assign pat_eff = pat_q;
`endif

  // A saturated count never returns to zero, so err_q==0 means "no miscompare yet".
  assign mismatch = cmp_vld_q && (ram_dout != cmp_exp_q);
  assign err_d    = (mismatch && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  assign ferr_d   = (mismatch && (err_q == 16'd0)) ? cmp_addr_q : ferr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_exp_q  <= '0;
`ifdef BIST_INV_PASS_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      cmp_vld_q <= 1'b0;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WRITE;
            pat_q   <= pattern;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            we_q    <= 1'b1;
            addr_q  <= '0;
            din_q   <= pattern;
`ifdef BIST_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (addr_last) begin
            state_q <= S_READ;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
          end else begin
            addr_q  <= addr_inc;
            din_q   <= pat_eff ^ DW'(addr_inc);
          end
        end
        S_READ: begin
          cmp_vld_q  <= 1'b1;
          cmp_addr_q <= addr_q;
          cmp_exp_q  <= pat_eff ^ DW'(addr_q);
          addr_q     <= addr_inc;
          if (addr_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
`ifdef BIST_INV_PASS_EN
          if (!inv_q) begin
            inv_q   <= 1'b1;
            state_q <= S_WRITE;
            we_q    <= 1'b1;
            addr_q  <= '0;
            din_q   <= ~pat_q;
          end else
`endif
          begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef BIST_INV_PASS_EN
          inv_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign ram_we         = we_q;
  assign ram_addr       = addr_q;
  assign ram_din        = din_q;

endmodule
